idct_block_reorder: RTL and testbench

- Upstream neighbour of the row IDCT stage. Accepts one block of 64 dequantized coefficients, 11-bit signed, in JPEG zigzag order, one per handshake.
- De-zigzags them into a two-bank (ping-pong) 8x8 buffer.
- Emits the block as 8 rows of 8 packed coefficients, the exact 88-bit format the row IDCT consumes.
- Supports early end-of-block: all unwritten positions read as zero.

---
 rtl/idct_block_reorder.sv | 140 ++++++++++++++
 tb/tb_idct_block_reorder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_block_reorder.sv
// De-zigzags one block of 64 coefficients into a ping-pong 8x8 buffer and emits 8 packed rows.
// Latency: first row registered on the commit edge; backpressure holds the row and stalls input when both banks are full.
module idct_block_reorder #(
  parameter int COEF_W = 11,
  parameter int N      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*COEF_W-1:0]      out_row,
  output logic [2:0]               out_row_idx,
  output logic                     out_last
);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [COEF_W-1:0]   r_mem [2][64];
  logic [63:0]         r_mask [2];
  logic [1:0]          r_full;
  logic                r_wbank;
  logic                r_rbank;
  logic [5:0]          r_cnt;
  logic [2:0]          r_rd_row;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [N*COEF_W-1:0] r_out_row;
  logic [2:0]          r_out_idx;
  logic                r_out_last;

  logic                w_acc;
  logic                w_commit;
  logic                w_rel;
  logic                w_rb_nxt;
  logic                w_wb_nxt;
  logic [1:0]          w_full_nxt;
  logic                w_load;
  logic [5:0]          w_zz;
  logic                w_byp;
  logic                w_clr;
  logic [5:0]          w_cidx [N];
  logic [N*COEF_W-1:0] w_row;

  assign w_acc    = in_valid && r_in_ready;
  assign w_commit = w_acc && (in_last || (r_cnt == 6'd63));
  assign w_rel    = r_out_valid && out_ready && r_out_last;
  assign w_rb_nxt = r_rbank ^ w_rel;
  assign w_wb_nxt = r_wbank ^ w_commit;
  assign w_zz     = ZZ[r_cnt];

  always_comb begin
    w_full_nxt = r_full;
    if (w_commit) w_full_nxt[r_wbank] = 1'b1;
    if (w_rel)    w_full_nxt[r_rbank] = 1'b0;
  end

  // A row can be loaded from the bank that is committing this very cycle, so the
  // incoming coefficient and the first-write mask clear are bypassed into the row.
  assign w_load = w_full_nxt[w_rb_nxt] && (!r_out_valid || out_ready);
  assign w_byp  = w_acc && (r_wbank == w_rb_nxt);
  assign w_clr  = w_byp && (r_cnt == 6'd0);

  always_comb begin
    for (int c = 0; c < N; c++) begin
      w_cidx[c] = {r_rd_row, 3'(c)};
    end
  end

  always_comb begin
    w_row = '0;
    for (int c = 0; c < N; c++) begin
      if (w_byp && (w_zz == w_cidx[c])) begin
        w_row[(N-1-c)*COEF_W +: COEF_W] = in_coef;
      end else if (!w_clr && r_mask[w_rb_nxt][w_cidx[c]]) begin
        w_row[(N-1-c)*COEF_W +: COEF_W] = r_mem[w_rb_nxt][w_cidx[c]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wbank][w_zz] <= in_coef;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask[0]   <= '0;
      r_mask[1]   <= '0;
      r_full      <= 2'b00;
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_cnt       <= 6'd0;
      r_rd_row    <= 3'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_idx   <= 3'd0;
      r_out_last  <= 1'b0;
    end else begin
      // First write of a block replaces the mask, discarding the previous block's bits.
      if (w_acc) begin
        if (r_cnt == 6'd0) r_mask[r_wbank] <= 64'd1 << w_zz;
        else               r_mask[r_wbank][w_zz] <= 1'b1;
      end
      if (w_acc) r_cnt <= w_commit ? 6'd0 : r_cnt + 6'd1;
      r_full     <= w_full_nxt;
      r_wbank    <= w_wb_nxt;
      r_rbank    <= w_rb_nxt;
      r_in_ready <= ~w_full_nxt[w_wb_nxt];
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_row   <= w_row;
        r_out_idx   <= r_rd_row;
        r_out_last  <= (r_rd_row == 3'd7);
        r_rd_row    <= r_rd_row + 3'd1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_row     = r_out_row;
  assign out_row_idx = r_out_idx;
  assign out_last    = r_out_last;

endmodule

// File: tb/tb_idct_block_reorder.sv
// Bench for idct_block_reorder: queue-based block model with a per-cycle checker plus literal row pins.
module tb_idct_block_reorder;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [10:0] in_coef;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [87:0]        out_row;
  logic [2:0]         out_row_idx;
  logic               out_last;

  idct_block_reorder #(.COEF_W(11), .N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          zz_tb [64];
  int          mval [64];
  bit          mwr [64];
  int          mcnt = 0;
  int          outstanding = 0;
  logic [87:0] exp_row_q [$];
  int          exp_idx_q [$];
  logic [87:0] cap [8];
  int          nrows = 0;
  int          stall_cyc = 0;
  bit          prev_stall = 0;
  logic [87:0] prev_row;
  logic [2:0]  prev_idx;
  int          blk [64];
  bit          rnd_en = 0;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic die(input string what);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", what);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench aborted");
  endtask

  function automatic logic [87:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    int v [8];
    logic [87:0] r;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    r = '0;
    for (int c = 0; c < 8; c++) r[(7-c)*11 +: 11] = v[c][10:0];
    return r;
  endfunction

  // Reference: zigzag walk along anti-diagonals, alternating direction.
  function automatic void build_zz();
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8 ? s : 7); r >= 0 && s - r < 8; r--) begin zz_tb[k] = 8*r + (s-r); k++; end
      end else begin
        for (int r = (s < 8 ? 0 : s - 7); r < 8 && s - r >= 0; r++) begin zz_tb[k] = 8*r + (s-r); k++; end
      end
    end
  endfunction

  function automatic void model_commit();
    logic [87:0] row;
    for (int r = 0; r < 8; r++) begin
      row = '0;
      for (int c = 0; c < 8; c++) begin
        if (mwr[8*r+c]) row[(7-c)*11 +: 11] = mval[8*r+c][10:0];
      end
      exp_row_q.push_back(row);
      exp_idx_q.push_back(r);
    end
    for (int i = 0; i < 64; i++) mwr[i] = 0;
    mcnt = 0;
    outstanding++;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_row_q.delete();
      exp_idx_q.delete();
      for (int i = 0; i < 64; i++) mwr[i] = 0;
      mcnt = 0;
      outstanding = 0;
      prev_stall = 0;
    end else begin
      chk("in_ready", 88'(in_ready), 88'(outstanding < 2));
      if (in_valid && !in_ready) stall_cyc++;
      if (prev_stall) begin
        chk("hold_valid", 88'(out_valid), 88'(1));
        chk("hold_row", out_row, prev_row);
        chk("hold_idx", 88'(out_row_idx), 88'(prev_idx));
      end
      prev_stall = out_valid && !out_ready;
      prev_row   = out_row;
      prev_idx   = out_row_idx;
      if (out_valid && out_ready) begin
        if (exp_row_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_row: got idx %0d row %h, expected no row", out_row_idx, out_row);
        end else begin
          int ei;
          logic [87:0] er;
          er = exp_row_q.pop_front();
          ei = exp_idx_q.pop_front();
          chk("row_data", out_row, er);
          chk("row_idx", 88'(out_row_idx), 88'(ei));
          chk("row_last", 88'(out_last), 88'(ei == 7));
          cap[out_row_idx] = out_row;
          nrows++;
          if (ei == 7) outstanding--;
        end
      end
      if (in_valid && in_ready) begin
        mval[zz_tb[mcnt]] = int'(in_coef);
        mwr[zz_tb[mcnt]]  = 1;
        mcnt++;
        if (in_last || mcnt == 64) model_commit();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_coef(input int v, input bit l);
    int budget;
    budget = 0;
    in_valid = 1'b1;
    in_coef  = 11'(v);
    in_last  = l;
    @(negedge clk);
    while (!in_ready) begin
      budget++;
      if (budget > 3000) die("in_ready_wait");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_block(input int n, input bit gaps, input bit use_last);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_coef(blk[i], use_last && (i == n - 1));
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_row_q.size() != 0 || out_valid) && b < 3000) begin
      @(posedge clk);
      #2;
      b++;
    end
    tests++;
    if (b >= 3000) begin
      fails++;
      $display("FAIL drain: %0d rows pending, expected 0", exp_row_q.size());
    end
  endtask

  task automatic wait_row(input int idx);
    int b;
    b = 0;
    @(posedge clk);
    #1;
    while (!(out_valid && out_row_idx == 3'(idx)) && b < 3000) begin
      @(posedge clk);
      #1;
      b++;
    end
    tests++;
    if (b >= 3000) begin
      fails++;
      $display("FAIL wait_row%0d: row never presented, expected it", idx);
    end
  endtask

  initial begin
    int n0;
    build_zz();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_coef = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 88'(in_ready), 88'(1));
    chk("rst_out_valid", 88'(out_valid), 88'(0));
    chk("rst_out_row", out_row, 88'(0));
    chk("rst_out_idx", 88'(out_row_idx), 88'(0));
    chk("rst_out_last", 88'(out_last), 88'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full block, in_coef = k
    for (int i = 0; i < 64; i++) blk[i] = i;
    send_block(64, 0, 0);
    chk("first_valid_latency", 88'(out_valid), 88'(1));
    drain();
    chk("full_row0", cap[0], pack8(0, 1, 5, 6, 14, 15, 27, 28));
    chk("full_row7", cap[7], pack8(35, 36, 48, 49, 57, 58, 62, 63));

    // Random full block into bank 1, then EOB block over bank 0's stale data
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 2047)) - 1024;
    send_block(64, 0, 0);
    drain();
    blk[0] = 100; blk[1] = -5; blk[2] = 7;
    send_block(3, 0, 1);
    drain();
    chk("eob_row0", cap[0], pack8(100, -5, 0, 0, 0, 0, 0, 0));
    chk("eob_row1", cap[1], pack8(7, 0, 0, 0, 0, 0, 0, 0));
    for (int r = 2; r < 8; r++) chk("eob_zero_row", cap[r], 88'(0));

    // Backpressure mid-row 3 while a second block fills the other bank
    fork
      begin
        for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 2047)) - 1024;
        send_block(64, 0, 0);
        for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 2047)) - 1024;
        send_block(64, 0, 0);
      end
      begin
        int b;
        wait_row(3);
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        b = 0;
        while (in_ready && b < 300) begin @(posedge clk); #1; b++; end
        chk("both_banks_full", 88'(in_ready), 88'(0));
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Ping-pong: all 1 then all -1024, continuous
    stall_cyc = 0;
    for (int i = 0; i < 64; i++) blk[i] = 1;
    send_block(64, 0, 0);
    for (int i = 0; i < 64; i++) blk[i] = -1024;
    send_block(64, 0, 0);
    drain();
    chk("pingpong_stall_le1", 88'(stall_cyc <= 1), 88'(1));
    chk("pingpong_b_row0", cap[0], pack8(-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024));
    chk("pingpong_b_row7", cap[7], {8{11'h400}});

    // in_last on the 64th coefficient, then one more coefficient
    n0 = nrows;
    for (int i = 0; i < 64; i++) blk[i] = i + 1;
    send_block(64, 0, 1);
    blk[0] = 55;
    send_block(1, 0, 1);
    drain();
    chk("last64_row_count", 88'(nrows - n0), 88'(16));
    chk("last64_next_row0", cap[0], pack8(55, 0, 0, 0, 0, 0, 0, 0));

    // Randomized blocks, gaps and backpressure
    rnd_en = 1;
    for (int b = 0; b < 8; b++) begin
      int len;
      bit ul;
      len = $urandom_range(1, 64);
      ul = (len < 64) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 2047)) - 1024;
      send_block(len, 1, ul);
    end
    rnd_en = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset while row 4 is held
    for (int i = 0; i < 64; i++) blk[i] = 500 - i;
    send_block(64, 0, 0);
    wait_row(4);
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_valid", 88'(out_valid), 88'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_reset_in_ready", 88'(in_ready), 88'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) blk[i] = i;
    send_block(64, 0, 0);
    drain();
    chk("post_reset_row0", cap[0], pack8(0, 1, 5, 6, 14, 15, 27, 28));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
